// File: rtl/inst_loader.sv
// inst_loader: boot-time writer for instruction RAM; assembles big-endian words from a byte
// stream and holds the core in reset until the whole image is written.
module inst_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        start,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);
    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, DONE, ERR} state_t;

    state_t      state, state_next;
    logic [7:0]  cnt_hi;
    logic [15:0] count;
    logic [15:0] hdr_count;
    logic [1:0]  byte_idx;
    logic [23:0] asm_word;
    logic        xfer;
    logic        last_word;
    logic        rearm;

    assign busy      = (state == HDR_HI) || (state == HDR_LO) || (state == DATA);
    assign done      = (state == DONE);
    assign err       = (state == ERR);
    assign in_ready  = busy;
    assign xfer      = in_valid & in_ready;
    assign hdr_count = {cnt_hi, in_data};
    // words_loaded < count here, so the increment cannot overflow
    assign last_word = (words_loaded + 16'd1) == count;
    assign rearm     = start & (done | err);

    always_comb begin
        state_next = state;
        case (state)
            HDR_HI:  state_next = xfer ? HDR_LO : HDR_HI;
            HDR_LO:  if (xfer) state_next = (hdr_count == 16'd0) ? DONE :
                                            ({16'd0, hdr_count} > MAX_W) ? ERR : DATA;
            DATA:    if (xfer && byte_idx == 2'd3 && last_word) state_next = DONE;
            DONE:    state_next = start ? HDR_HI : DONE;
            ERR:     state_next = start ? HDR_HI : ERR;
            default: state_next = HDR_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= HDR_HI;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= 32'd0;
            cpu_rst_n    <= 1'b0;
            words_loaded <= 16'd0;
            byte_idx     <= 2'd0;
            count        <= 16'd0;
            cnt_hi       <= 8'd0;
            asm_word     <= 24'd0;
        end else begin
            state     <= state_next;
            mem_we    <= 1'b0;
            // a re-arm must drop the core reset on the same edge that leaves DONE
            cpu_rst_n <= done & ~start;
            if (xfer && state == HDR_HI) cnt_hi <= in_data;
            if (xfer && state == HDR_LO) count <= hdr_count;
            if (xfer && state == DATA) begin
                asm_word <= {asm_word[15:0], in_data};
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    mem_we       <= 1'b1;
                    mem_wdata    <= {asm_word, in_data};
                    mem_addr     <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
                    words_loaded <= words_loaded + 16'd1;
                end
            end
            if (rearm) begin
                words_loaded <= 16'd0;
                byte_idx     <= 2'd0;
                mem_addr     <= BASE_ADDR;
            end
        end
    end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: scoreboard bench for inst_loader; expected writes are queued as
// the stream is driven and popped whenever the DUT strobes mem_we.
module tb_inst_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        start = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    int n_checks = 0;
    int n_fail = 0;
    int n_we = 0;
    logic [63:0] exp_q[$];

    inst_loader dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .start(start), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done),
        .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            logic [63:0] e;
            n_we++;
            check("cpu_held_during_we", {31'd0, cpu_rst_n}, 32'd0);
            if (exp_q.size() == 0) check("unexpected_we", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("we_addr", mem_addr, e[63:32]);
                check("we_data", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    // Streams bytes; optionally verifies the core stays in reset before the last byte lands
    task automatic stream(input logic [7:0] b[$], input int gap, input bit chk_rst);
        for (int i = 0; i < b.size(); i++) begin
            if (chk_rst) check("cpu_rst_while_loading", {31'd0, cpu_rst_n}, 32'd0);
            send(b[i], (i == b.size() - 1) ? 0 : gap);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    logic [7:0] img2[$] = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};

    initial begin
        int we0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        check("rst_words", {16'd0, words_loaded}, 32'd0);

        // Basic back-to-back load
        exp_q.push_back({32'h0, 32'h24080005});
        exp_q.push_back({32'h4, 32'h01095020});
        stream(img2, 0, 1'b1);
        check("basic_done", {31'd0, done}, 32'd1);
        check("basic_cpu_rst_at_last_we", {31'd0, cpu_rst_n}, 32'd0);
        @(posedge clk); #1;
        check("basic_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        check("basic_words", {16'd0, words_loaded}, 32'd2);
        check("basic_we_count", n_we, 2);
        check("basic_q_empty", exp_q.size(), 0);

        // Re-arm from DONE, then a 1-word image with an ignored mid-load start
        pulse_start();
        check("rearm_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        check("rearm_words", {16'd0, words_loaded}, 32'd0);
        check("rearm_busy", {31'd0, busy}, 32'd1);
        exp_q.push_back({32'h0, 32'hDEADBEEF});
        send(8'h00, 0); send(8'h01, 0); send(8'hDE, 0);
        start = 1'b1;
        send(8'hAD, 0);
        start = 1'b0;
        send(8'hBE, 0); send(8'hEF, 0);
        check("rearm_done", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        check("rearm_words_after", {16'd0, words_loaded}, 32'd1);
        check("rearm_we_count", n_we, 3);
        check("rearm_q_empty", exp_q.size(), 0);

        // Gapped stream
        pulse_start();
        exp_q.push_back({32'h0, 32'h24080005});
        exp_q.push_back({32'h4, 32'h01095020});
        stream(img2, 3, 1'b1);
        check("gap_cpu_rst_at_last_we", {31'd0, cpu_rst_n}, 32'd0);
        @(posedge clk); #1;
        check("gap_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        check("gap_we_count", n_we, 5);
        check("gap_q_empty", exp_q.size(), 0);

        // Zero-length image
        pulse_start();
        we0 = n_we;
        send(8'h00, 0); send(8'h00, 0);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_cpu_rst_early", {31'd0, cpu_rst_n}, 32'd0);
        @(posedge clk); #1;
        check("zero_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        check("zero_no_we", n_we, we0);

        // Oversize image: 0x0401 = 1025 words
        pulse_start();
        send(8'h04, 0); send(8'h01, 0);
        check("over_err", {31'd0, err}, 32'd1);
        check("over_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1; in_data = 8'h55;
        repeat (6) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        check("over_err_hold", {31'd0, err}, 32'd1);
        check("over_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        check("over_no_we", n_we, we0);

        // Re-arm from ERR, then reset after two bytes of word 1
        pulse_start();
        check("err_rearm_busy", {31'd0, busy}, 32'd1);
        send(8'h00, 0); send(8'h02, 0); send(8'h24, 0); send(8'h08, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("midrst_busy", {31'd0, busy}, 32'd1);
        check("midrst_words", {16'd0, words_loaded}, 32'd0);
        check("midrst_addr", mem_addr, 32'h0);
        check("midrst_no_we", n_we, we0);
        exp_q.push_back({32'h0, 32'h24080005});
        exp_q.push_back({32'h4, 32'h01095020});
        stream(img2, 1, 1'b1);
        @(posedge clk); #1;
        check("midrst_reload_done", {31'd0, done}, 32'd1);
        check("midrst_reload_cpu", {31'd0, cpu_rst_n}, 32'd1);
        check("midrst_reload_words", {16'd0, words_loaded}, 32'd2);
        check("midrst_we_count", n_we, we0 + 2);
        check("midrst_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
